// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch from decode to the xpip/dpip/lpip pipes.
// Small op FIFO, one issue per cycle, per-pipe credit counters and sticky err.
module dispatch_ctrl #(
    parameter int W_uops     = 6,
    parameter int W_pops     = 3,
    parameter int W_addr_prf = 5,
    parameter int W_data_arf = 32,
    parameter int DEPTH      = 4,
    parameter int CRED_X     = 4,
    parameter int CRED_D     = 2,
    parameter int CRED_L     = 4,
    parameter int W_cred     = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [W_pops-1:0]     in_pops,
    input  logic [W_uops-1:0]     in_uops,
    input  logic [W_addr_prf-1:0] in_rd,
    input  logic [W_data_arf-1:0] in_pc,
    output logic                  stall,
    output logic                  out_x_valid,
    output logic                  out_d_valid,
    output logic                  out_l_valid,
    output logic [W_uops-1:0]     out_uops,
    output logic [W_addr_prf-1:0] out_rd,
    output logic [W_data_arf-1:0] out_pc,
    input  logic                  x_ret,
    input  logic                  d_ret,
    input  logic                  l_ret,
    output logic                  err
);

    localparam int W_ptr = $clog2(DEPTH);
    localparam int W_cnt = W_ptr + 1;

    localparam logic [W_pops-1:0] P_X = W_pops'(0);
    localparam logic [W_pops-1:0] P_D = W_pops'(1);
    localparam logic [W_pops-1:0] P_L = W_pops'(2);

    localparam logic [W_cred-1:0] MAX_X = W_cred'(CRED_X);
    localparam logic [W_cred-1:0] MAX_D = W_cred'(CRED_D);
    localparam logic [W_cred-1:0] MAX_L = W_cred'(CRED_L);

    logic [W_pops-1:0]     r_q_pops [DEPTH];
    logic [W_uops-1:0]     r_q_uops [DEPTH];
    logic [W_addr_prf-1:0] r_q_rd   [DEPTH];
    logic [W_data_arf-1:0] r_q_pc   [DEPTH];

    logic [W_ptr-1:0]  r_rptr;
    logic [W_ptr-1:0]  r_wptr;
    logic [W_cnt-1:0]  r_count;
    logic [W_cred-1:0] r_cred_x;
    logic [W_cred-1:0] r_cred_d;
    logic [W_cred-1:0] r_cred_l;

    logic              w_stall;
    logic              w_enq;
    logic              w_deq;
    logic              w_head_ok;
    logic [W_pops-1:0] w_hpops;
    logic              w_iss_x;
    logic              w_iss_d;
    logic              w_iss_l;
    logic              w_iss;
    logic              w_illegal;
    logic              w_ovf_x;
    logic              w_ovf_d;
    logic              w_ovf_l;

    // Credit step: +1 on return, -1 on issue, hold on overflow or when both fire.
    function automatic logic [W_cred-1:0] cred_next(
        input logic [W_cred-1:0] c,
        input logic              ret,
        input logic              iss,
        input logic              ovf
    );
        logic [W_cred-1:0] n;
        n = c;
        if (ret && !iss && !ovf) begin
            n = c + W_cred'(1);
        end else if (iss && !ret) begin
            n = c - W_cred'(1);
        end
        return n;
    endfunction

    // stall looks only at the registered occupancy, never at a same-cycle dequeue.
    assign w_stall   = (r_count == W_cnt'(DEPTH));
    assign stall     = w_stall;
    assign w_enq     = in_valid && !w_stall && !clear;
    assign w_head_ok = (r_count != '0) && !clear;
    assign w_hpops   = r_q_pops[r_rptr];

    assign w_iss_x   = w_head_ok && (w_hpops == P_X) && (r_cred_x != '0);
    assign w_iss_d   = w_head_ok && (w_hpops == P_D) && (r_cred_d != '0);
    assign w_iss_l   = w_head_ok && (w_hpops == P_L) && (r_cred_l != '0);
    assign w_iss     = w_iss_x || w_iss_d || w_iss_l;
    assign w_illegal = w_head_ok && (w_hpops != P_X)
                       && (w_hpops != P_D) && (w_hpops != P_L);
    assign w_deq     = w_iss || w_illegal;

    // A return that would push a counter past its reset value is an overflow.
    assign w_ovf_x   = x_ret && !w_iss_x && (r_cred_x == MAX_X);
    assign w_ovf_d   = d_ret && !w_iss_d && (r_cred_d == MAX_D);
    assign w_ovf_l   = l_ret && !w_iss_l && (r_cred_l == MAX_L);

    // FIFO storage: payload only, validity is carried by the pointers.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_q_pops[r_wptr] <= in_pops;
            r_q_uops[r_wptr] <= in_uops;
            r_q_rd[r_wptr]   <= in_rd;
            r_q_pc[r_wptr]   <= in_pc;
        end
    end

    // Pointers and occupancy; clear empties the queue outright.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + W_ptr'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + W_ptr'(1);
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + W_cnt'(1);
                2'b01:   r_count <= r_count - W_cnt'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-pipe credits survive clear so in-flight returns still balance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cred_x <= MAX_X;
            r_cred_d <= MAX_D;
            r_cred_l <= MAX_L;
        end else begin
            r_cred_x <= cred_next(r_cred_x, x_ret, w_iss_x, w_ovf_x);
            r_cred_d <= cred_next(r_cred_d, d_ret, w_iss_d, w_ovf_d);
            r_cred_l <= cred_next(r_cred_l, l_ret, w_iss_l, w_ovf_l);
        end
    end

    // Registered issue strobes and payload; payload holds between issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_x_valid <= 1'b0;
            out_d_valid <= 1'b0;
            out_l_valid <= 1'b0;
            out_uops    <= '0;
            out_rd      <= '0;
            out_pc      <= '0;
        end else begin
            out_x_valid <= w_iss_x;
            out_d_valid <= w_iss_d;
            out_l_valid <= w_iss_l;
            if (w_iss) begin
                out_uops <= r_q_uops[r_rptr];
                out_rd   <= r_q_rd[r_rptr];
                out_pc   <= r_q_pc[r_rptr];
            end
        end
    end

    // Sticky error for discarded illegal ops and credit overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (w_illegal || w_ovf_x || w_ovf_d || w_ovf_l) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: table vectors, directed corner sequences and random
// traffic, all compared against a queue-based model of the dispatcher.
module tb_dispatch_ctrl;

    localparam int DEPTH = 4;
    localparam int MX    = 4;
    localparam int MD    = 2;
    localparam int ML    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_pops = '0;
    logic [5:0]  in_uops = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_pc = '0;
    logic        x_ret = 1'b0;
    logic        d_ret = 1'b0;
    logic        l_ret = 1'b0;
    logic        stall;
    logic        out_x_valid;
    logic        out_d_valid;
    logic        out_l_valid;
    logic [5:0]  out_uops;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        err;

    dispatch_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_pops     (in_pops),
        .in_uops     (in_uops),
        .in_rd       (in_rd),
        .in_pc       (in_pc),
        .stall       (stall),
        .out_x_valid (out_x_valid),
        .out_d_valid (out_d_valid),
        .out_l_valid (out_l_valid),
        .out_uops    (out_uops),
        .out_rd      (out_rd),
        .out_pc      (out_pc),
        .x_ret       (x_ret),
        .d_ret       (d_ret),
        .l_ret       (l_ret),
        .err         (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  pops;
        logic [5:0]  uops;
        logic [4:0]  rd;
        logic [31:0] pc;
    } op_t;

    typedef struct {
        logic        v;
        logic [2:0]  p;
        logic [5:0]  u;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        clr;
        logic        xr;
        logic        dr;
        logic        lr;
        logic        ex;
        logic        ed;
        logic        el;
    } vec_t;

    // Reference model state: op queue, credit integers, expected outputs.
    op_t         mq[$];
    int          cx;
    int          cd;
    int          cl;
    logic        m_err;
    logic        m_xv;
    logic        m_dv;
    logic        m_lv;
    logic [5:0]  m_uops;
    logic [4:0]  m_rd;
    logic [31:0] m_pc;
    bit          m_acc;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cx = MX;
        cd = MD;
        cl = ML;
        m_err = 1'b0;
        m_xv = 1'b0;
        m_dv = 1'b0;
        m_lv = 1'b0;
        m_uops = '0;
        m_rd = '0;
        m_pc = '0;
    endtask

    function automatic int cred_upd(input int c, input logic ret,
                                    input bit iss, input int mx);
        if (ret && !iss && c == mx) begin
            m_err = 1'b1;
            return c;
        end
        return c + (ret ? 1 : 0) - (iss ? 1 : 0);
    endfunction

    // One clock edge of the dispatcher, from the rules on ops and credits.
    task automatic model_step();
        bit  full;
        int  pipe;
        op_t h;
        full = (mq.size() == DEPTH);
        pipe = -1;
        m_acc = 1'b0;
        m_xv = 1'b0;
        m_dv = 1'b0;
        m_lv = 1'b0;
        if (!clear && mq.size() > 0) begin
            h = mq[0];
            if (h.pops == 3'd0 && cx > 0) pipe = 0;
            else if (h.pops == 3'd1 && cd > 0) pipe = 1;
            else if (h.pops == 3'd2 && cl > 0) pipe = 2;
            else if (h.pops > 3'd2) begin
                void'(mq.pop_front());
                m_err = 1'b1;
            end
            if (pipe >= 0) begin
                void'(mq.pop_front());
                m_uops = h.uops;
                m_rd = h.rd;
                m_pc = h.pc;
                m_xv = (pipe == 0);
                m_dv = (pipe == 1);
                m_lv = (pipe == 2);
            end
        end
        cx = cred_upd(cx, x_ret, pipe == 0, MX);
        cd = cred_upd(cd, d_ret, pipe == 1, MD);
        cl = cred_upd(cl, l_ret, pipe == 2, ML);
        if (in_valid && !full && !clear) begin
            mq.push_back('{pops: in_pops, uops: in_uops, rd: in_rd, pc: in_pc});
            m_acc = 1'b1;
        end
        if (clear) mq.delete();
    endtask

    task automatic compare();
        chk("x_valid", out_x_valid, m_xv);
        chk("d_valid", out_d_valid, m_dv);
        chk("l_valid", out_l_valid, m_lv);
        chk("uops", out_uops, m_uops);
        chk("rd", out_rd, m_rd);
        chk("pc", out_pc, m_pc);
        chk("err", err, m_err);
        chk("stall", stall, mq.size() == DEPTH);
    endtask

    // Called at posedge+1; drives inputs, advances one edge, checks at +1.
    task automatic step(input logic v, input logic [2:0] p,
                        input logic [5:0] u, input logic [4:0] rd,
                        input logic [31:0] pc, input logic clr,
                        input logic xr, input logic dr, input logic lr);
        in_valid = v;
        in_pops = p;
        in_uops = u;
        in_rd = rd;
        in_pc = pc;
        clear = clr;
        x_ret = xr;
        d_ret = dr;
        l_ret = lr;
        @(posedge clock);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Return credits until every pipe is back at its reset count.
    task automatic settle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, cx < MX, cd < MD, cl < ML);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #2;
        model_reset();
        compare();
        @(posedge clock);
        #1;
        compare();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] p,
                                input logic [5:0] u, input logic [4:0] rd,
                                input logic [31:0] pc, input logic dr,
                                input logic ex, input logic ed,
                                input logic el);
        vec_t t;
        t.v = v;
        t.p = p;
        t.u = u;
        t.rd = rd;
        t.pc = pc;
        t.clr = 1'b0;
        t.xr = 1'b0;
        t.dr = dr;
        t.lr = 1'b0;
        t.ex = ex;
        t.ed = ed;
        t.el = el;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        int   dcount;
        int   r;
        logic [2:0] rp;

        tbl.push_back(mk(1, 0, 6'h05, 3, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 6'h11, 4, 32'h200, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 6'h12, 5, 32'h204, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 6'h13, 6, 32'h208, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 6'h14, 7, 32'h20c, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        model_reset();
        @(posedge clock);
        #1;
        compare();
        chk("reset_stall", stall, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;

        // Single xpip op, dpip credit exhaustion and in-order blocking.
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].p, tbl[i].u, tbl[i].rd, tbl[i].pc,
                 tbl[i].clr, tbl[i].xr, tbl[i].dr, tbl[i].lr);
            chk($sformatf("tbl%0d_x", i), out_x_valid, tbl[i].ex);
            chk($sformatf("tbl%0d_d", i), out_d_valid, tbl[i].ed);
            chk($sformatf("tbl%0d_l", i), out_l_valid, tbl[i].el);
            if (i == 1) begin
                chk("first_uops", out_uops, 6'h05);
                chk("first_rd", out_rd, 3);
                chk("first_pc", out_pc, 32'h100);
            end
        end

        // Blocked head fills the FIFO; the fifth op waits for a slot.
        step(1, 1, 6'h21, 8, 32'h300, 0, 0, 0, 0);
        step(1, 0, 6'h22, 9, 32'h304, 0, 0, 0, 0);
        step(1, 0, 6'h23, 10, 32'h308, 0, 0, 0, 0);
        step(1, 0, 6'h24, 11, 32'h30c, 0, 0, 0, 0);
        chk("stall_full", stall, 1);
        step(1, 2, 6'h25, 12, 32'h310, 0, 0, 0, 0);
        chk("stall_hold", stall, 1);
        step(1, 2, 6'h25, 12, 32'h310, 0, 0, 1, 0);
        m_acc = 1'b0;
        for (int k = 0; k < 10 && !m_acc; k++)
            step(1, 2, 6'h25, 12, 32'h310, 0, cx < MX, 0, 0);
        chk("fifth_accepted", m_acc, 1);
        settle(12);

        // Clear with three ops queued behind an exhausted dpip.
        for (int k = 0; k < 5; k++)
            step(1, 1, 6'(6'h30 + k), 5'(k), 32'h400 + 4 * k, 0, 0, 0, 0);
        chk("clear_pre_stall", stall, 0);
        step(1, 0, 6'h3f, 1, 32'h500, 1, 0, 0, 0);
        chk("clear_x", out_x_valid, 0);
        chk("clear_d", out_d_valid, 0);
        chk("clear_l", out_l_valid, 0);
        idle(1);
        chk("clear_after_d", out_d_valid, 0);
        step(1, 0, 6'h2a, 2, 32'h600, 0, 0, 0, 0);
        idle(1);
        chk("post_clear_x", out_x_valid, 1);
        chk("post_clear_pc", out_pc, 32'h600);
        step(1, 1, 6'h2b, 3, 32'h604, 0, 0, 0, 0);
        idle(2);
        settle(6);

        // Credit overflow and illegal pops both latch err until reset.
        reset_pulse();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_err", err, 1);
        idle(1);
        reset_pulse();
        chk("err_cleared", err, 0);
        step(1, 3'b111, 6'h3c, 4, 32'h700, 0, 0, 0, 0);
        idle(1);
        chk("illegal_err", err, 1);
        chk("illegal_nox", out_x_valid, 0);
        chk("illegal_nod", out_d_valid, 0);
        chk("illegal_nol", out_l_valid, 0);
        idle(3);
        chk("err_sticky", err, 1);

        // Mid-stream reset reloads credits with ops still in flight.
        step(1, 1, 6'h01, 1, 32'h800, 0, 0, 0, 0);
        step(1, 1, 6'h02, 2, 32'h804, 0, 0, 0, 0);
        step(1, 2, 6'h03, 3, 32'h808, 0, 0, 0, 0);
        step(1, 1, 6'h04, 4, 32'h80c, 0, 0, 0, 0);
        step(1, 0, 6'h05, 5, 32'h810, 0, 0, 0, 0);
        #2;
        reset_pulse();
        chk("rst_x", out_x_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_err", err, 0);
        dcount = 0;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 6'(6'h08 + k), 5'(k), 32'h900 + 4 * k, 0, 0, 0, 0);
            dcount += int'(out_d_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            dcount += int'(out_d_valid);
        end
        chk("d_credit_reload", dcount, 2);
        settle(8);
        reset_pulse();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            rp = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            step($urandom_range(0, 2) != 0, rp, 6'($urandom),
                 5'($urandom), $urandom,
                 $urandom_range(0, 29) == 0,
                 (cx < MX) ? ($urandom_range(0, 2) == 0)
                           : ($urandom_range(0, 60) == 0),
                 (cd < MD) ? ($urandom_range(0, 2) == 0)
                           : ($urandom_range(0, 60) == 0),
                 (cl < ML) ? ($urandom_range(0, 2) == 0)
                           : ($urandom_range(0, 60) == 0));
            if (k == 200) reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- In-order dispatch scheduler between the decode stage and the three execution pipes: execute (xpip), divide (dpip) and load/store (lpip).
- Buffers decoded ops in a small FIFO and issues at most one op per cycle to the pipe selected by its pops code.
- Tracks per-pipe reservation credits and generates `stall` back to decode.

Parameters:
- W_uops, 6, micro-op width
- W_pops, 3, pipe-select width
- W_addr_prf, 5, physical destination tag width
- W_data_arf, 32, PC width
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- CRED_X, 4, xpip credits at reset
- CRED_D, 2, dpip credits at reset
- CRED_L, 4, lpip credits at reset
- W_cred, 3, credit counter width (must hold max credit)

Ports:
- clock, input, 1, single clock, rising edge
- reset, input, 1, asynchronous active-high reset
- clear, input, 1, synchronous flush (mispredict/exception)
- in_valid, input, 1, decoded op present
- in_pops, input, W_pops, pipe select: 000 xpip, 001 dpip, 010 lpip
- in_uops, input, W_uops, micro-op
- in_rd, input, W_addr_prf, destination tag
- in_pc, input, W_data_arf, op PC
- stall, output, 1, decode must hold; high when FIFO full
- out_x_valid / out_d_valid / out_l_valid, output, 1 each, one-cycle issue strobe per pipe
- out_uops, output, W_uops, issued micro-op
- out_rd, output, W_addr_prf, issued tag
- out_pc, output, W_data_arf, issued PC
- x_ret / d_ret / l_ret, input, 1 each, pipe frees one slot (pulse)
- err, output, 1, sticky: illegal pops or credit overflow

Behaviour:
- Reset (async, immediate):
  - FIFO empty; all out_*_valid = 0; out_uops/out_rd/out_pc = 0.
  - stall = 0; err = 0.
  - Credits = CRED_X / CRED_D / CRED_L.
- `stall` is combinational from registered count only: stall = (count == DEPTH). It does not depend on same-cycle dequeue.
- Enqueue at an edge when in_valid && !stall && !clear. If in_valid is high while stall is high, the input is ignored; decode is required to hold it.
- Head issue decision, evaluated each cycle the FIFO is non-empty and clear = 0:
  - pops = 000/001/010 and the selected credit > 0: at the edge, dequeue the head, assert exactly one out_*_valid for the next cycle, load the payload registers, and decrement that credit.
  - Selected credit == 0: head blocks. All later entries wait (strict in-order), and all out_*_valid = 0.
  - pops not in {000, 001, 010}: dequeue and discard the head with no issue, and set err.
- out_*_valid are registered and low in any cycle without an issue. Payload registers hold their last value when no issue occurs.
- Latency: an op enqueued into an empty FIFO at edge E0 with credit available is issued at edge E1, so out_*_valid is high in the cycle after E1. Throughput is 1 op/cycle.
- Credits:
  - ret pulse increments the credit; issue decrements it.
  - Simultaneous ret and issue on the same pipe: net 0.
  - ret when credit already at its reset maximum: counter unchanged, err set.
- Pointers: read/write pointers wrap modulo DEPTH. count is updated for simultaneous enqueue and dequeue (net 0).
- clear:
  - At the edge, FIFO is emptied and all out_*_valid are 0 the next cycle; the enqueue and issue for that cycle are suppressed.
  - Credits are NOT reset; returns from in-flight ops still arrive.
  - clear together with reset: reset wins.
- err clears only on reset.
- Reset asserted mid-operation: everything returns to reset values asynchronously. Credits reload regardless of ops still in flight.

Test Plan:
- Reset, then one xpip op (pops=000, uops=6'h05, rd=3, pc=0x100) with in_valid at E0 → out_x_valid=1 in the cycle after E1 with uops=05, rd=3, pc=0x100; x credit 4→3.
- Three back-to-back dpip ops, no d_ret → first two issue on consecutive cycles; third blocks at head (credit 0). A following xpip op also waits. d_ret pulse → third issues next edge, then the xpip op.
- Hold the head blocked and drive 5 consecutive in_valid → stall rises when count=4; the 5th op is accepted only after the head issues; pointers wrap with no data corruption.
- FIFO holding 3 ops, assert clear for one cycle → no out_*_valid afterwards; credits unchanged. A new op after clear issues normally.
- Enqueue pops=3'b111 → no issue strobe; err=1 and stays 1 until reset. An l_ret with l credit at 4 also sets err, and the counter stays 4.
- Assert reset mid-stream with ops queued and credits partially consumed → outputs 0 immediately; credits return to 4/2/4.
